// File: rtl/mult_seq_ctrl.sv
// Control sequencer for a shift-add multiplier.
// Moore FSM steering an external product register datapath.
module mult_seq_ctrl #(
    parameter int N = 16,
    localparam int H = N / 2,
    localparam int IW = $clog2(H)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          start,
    input  logic          prod_lsb,
    output logic          loadh,
    output logic          loadl,
    output logic          sel_init,
    output logic          sel_add,
    output logic          shift,
    output logic          carry_ld,
    output logic          carry_clr,
    output logic [IW-1:0] iter,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_TEST,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;
    logic   last;

    assign last = (iter == IW'(H - 1));

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
            iter  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_INIT) begin
                iter <= '0;
            end else if (state == S_SHIFT) begin
                // wraps to 0 on the final step since H is a power of two
                iter <= iter + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        loadh     = 1'b0;
        loadl     = 1'b0;
        sel_init  = 1'b0;
        sel_add   = 1'b0;
        shift     = 1'b0;
        carry_ld  = 1'b0;
        carry_clr = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_INIT;
                end
            end
            S_INIT: begin
                busy      = 1'b1;
                sel_init  = 1'b1;
                loadh     = 1'b1;
                loadl     = 1'b1;
                carry_clr = 1'b1;
                state_nx  = S_TEST;
            end
            S_TEST: begin
                busy     = 1'b1;
                state_nx = prod_lsb ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                busy     = 1'b1;
                sel_add  = 1'b1;
                loadh    = 1'b1;
                carry_ld = 1'b1;
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                busy      = 1'b1;
                shift     = 1'b1;
                loadh     = 1'b1;
                loadl     = 1'b1;
                carry_clr = 1'b1;
                state_nx  = last ? S_DONE : S_TEST;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl driving a behavioural
// product-register datapath; expectations come from plain arithmetic.
module tb_mult_seq_ctrl;

    localparam int N = 16;
    localparam int H = N / 2;
    localparam int IW = $clog2(H);

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic          prod_lsb;
    logic          loadh;
    logic          loadl;
    logic          sel_init;
    logic          sel_add;
    logic          shift;
    logic          carry_ld;
    logic          carry_clr;
    logic [IW-1:0] iter;
    logic          busy;
    logic          done;

    mult_seq_ctrl #(.N(N)) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .prod_lsb  (prod_lsb),
        .loadh     (loadh),
        .loadl     (loadl),
        .sel_init  (sel_init),
        .sel_add   (sel_add),
        .shift     (shift),
        .carry_ld  (carry_ld),
        .carry_clr (carry_clr),
        .iter      (iter),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // product register datapath steered by the controller
    logic [H-1:0] hi;
    logic [H-1:0] lo;
    logic         carry;
    logic [H-1:0] mcand;
    logic [H-1:0] mplier;
    logic [H:0]   sum;
    logic         ovr;
    logic         ovr_val;

    assign sum = {1'b0, hi} + {1'b0, mcand};

    always @(posedge clk) begin
        if (sel_init && loadh && loadl) begin
            hi <= '0;
            lo <= mplier;
        end else if (sel_add && loadh) begin
            hi <= sum[H-1:0];
        end else if (shift && loadh && loadl) begin
            {hi, lo} <= {carry, hi, lo[H-1:1]};
        end
        if (carry_clr) begin
            carry <= 1'b0;
        end else if (carry_ld) begin
            carry <= sum[H];
        end
    end

    always_comb begin
        prod_lsb = lo[0];
        if (ovr) prod_lsb = ovr_val;
    end

    typedef struct {
        logic [N-1:0] prod;
        int           adds;
        int           done_cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   add_cnt = 0;
    int   shift_cnt = 0;
    bit   prev_done = 1'b0;

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // monitor: invariants every cycle, scoreboard pop on done
    always @(negedge clk) begin
        if (!clear) begin
            chk("mux_onehot", $countones({sel_init, sel_add, shift}), 
                longint'($countones({sel_init, sel_add, shift}) > 1 ? 1 : $countones({sel_init, sel_add, shift})));
            chk("loadl_src", longint'(loadl && !(sel_init || shift)), 0);
            if (sel_init || sel_add || shift) chk("busy_active", busy, 1);
            if (sel_init) begin
                shift_cnt = 0;
                add_cnt   = 0;
            end
            if (sel_add) add_cnt++;
            if (shift) begin
                chk("iter", iter, shift_cnt);
                shift_cnt++;
            end
            if (done) begin
                chk("done_single", prev_done, 0);
                chk("done_busy", busy, 0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("product", {hi, lo}, e.prod);
                    chk("add_cycles", add_cnt, e.adds);
                    chk("latency_cycle", cyc, e.done_cyc);
                end
                done_count++;
            end
            prev_done = done;
        end else begin
            add_cnt   = 0;
            shift_cnt = 0;
            prev_done = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {loadh, loadl, sel_init, sel_add, shift, carry_ld,
                   carry_clr, busy, done, iter}, 0);
    endtask

    task automatic push_exp(input logic [H-1:0] a, input logic [H-1:0] b,
                            input int c0);
        exp_t x;
        int   k;
        k = $countones(b);
        x.prod     = N'(a) * N'(b);
        x.adds     = k;
        x.done_cyc = c0 + 2 + N + k;
        q.push_back(x);
    endtask

    task automatic wait_done(input int target, input int budget,
                             input bit noise);
        int n = 0;
        while (done_count < target && n < budget) begin
            if (noise && busy && ($urandom_range(0, 2) == 0)) start = 1'b1;
            else start = 1'b0;
            step();
            n++;
        end
        start = 1'b0;
        if (done_count < target) chk("timeout", done_count, target);
    endtask

    task automatic run_op(input logic [H-1:0] a, input logic [H-1:0] b,
                          input bit noise);
        mcand  = a;
        mplier = b;
        clear  = 1'b0;
        start  = 1'b1;
        push_exp(a, b, cyc);
        step();
        start = 1'b0;
        wait_done(done_count + 1, 200, noise);
    endtask

    task automatic clear_rand(input int ncyc);
        clear = 1'b1;
        #1;
        chk_zero("clear_async");
        ovr = 1'b1;
        repeat (ncyc) begin
            start   = 1'($urandom);
            ovr_val = 1'($urandom);
            step();
            chk_zero("clear_hold");
        end
        ovr = 1'b0;
    endtask

    initial begin
        int n;
        int c0;
        int target;
        clear   = 1'b1;
        start   = 1'b0;
        ovr     = 1'b0;
        ovr_val = 1'b0;
        mcand   = '0;
        mplier  = '0;
        step();
        chk_zero("reset_state");

        clear_rand(20);
        // start rises on the very edge after clear drops
        run_op(8'd13, 8'd11, 1'b0);
        run_op(8'($urandom), 8'h00, 1'b0);
        run_op(8'($urandom), 8'hFF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'b1);
        end

        // abort mid-operation after the fifth shift
        mcand  = 8'd13;
        mplier = 8'd11;
        start  = 1'b1;
        push_exp(8'd13, 8'd11, cyc);
        step();
        start = 1'b0;
        step();
        n = 0;
        while (shift_cnt < 5 && n < 100) begin
            step();
            n++;
        end
        chk("abort_reach", shift_cnt, 5);
        clear = 1'b1;
        q.delete();
        #1;
        chk_zero("abort_clear");
        step();
        step();
        clear = 1'b0;
        repeat (30) step();
        chk("abort_idle", busy, 0);
        run_op(8'd13, 8'd11, 1'b0);

        // start held high across three operations
        mcand  = 8'($urandom);
        mplier = 8'h00;
        start  = 1'b1;
        c0     = cyc;
        for (int i = 0; i < 3; i++) begin
            push_exp(mcand, 8'h00, c0 + i * (N + 3));
        end
        target = done_count + 3;
        n = 0;
        while (done_count < target && n < 200) begin
            step();
            n++;
        end
        start = 1'b0;
        if (done_count < target) chk("held_timeout", done_count, target);
        repeat (3) step();
        chk("held_idle", busy, 0);

        for (int i = 0; i < 3; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'b0);
        end
        repeat (5) step();
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter: N, default 16, product width in bits; operands are N/2 bits; N/2 is a power of two, at least 2.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 clear  in  1  reset, asynchronous and active-high; forces IDLE and all outputs to their reset values immediately.
REQ-004 start  in  1  request to begin a multiply; sampled only in IDLE.
REQ-005 prod_lsb  in  1  bit 0 of the product register (current multiplier bit).
REQ-006 loadh  out  1  load enable, high half of the product register.
REQ-007 loadl  out  1  load enable, low half of the product register.
REQ-008 sel_init  out  1  datapath mux: high half <= 0, low half <= multiplier operand.
REQ-009 sel_add  out  1  datapath mux: high half <= high half + multiplicand (low N/2 bits of the sum).
REQ-010 shift  out  1  datapath mux: {carry, high, low} >> 1 into both halves.
REQ-011 carry_ld  out  1  capture the adder carry-out into the datapath carry flop.
REQ-012 carry_clr  out  1  clear the datapath carry flop.
REQ-013 iter  out  $clog2(N/2)  number of SHIFT steps completed in the current operation.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  single-cycle completion pulse.

Function
REQ-016 States: IDLE, INIT, TEST, ADD, SHIFT, DONE; binary encoding is free.
REQ-017 All outputs SHALL be decoded from the state register and iter only (Moore); no output depends combinationally on start or prod_lsb.
REQ-018 Outputs not listed for a state SHALL be 0 in that state.
REQ-019 IDLE: start=1 -> INIT; otherwise stay in IDLE.
REQ-020 INIT: sel_init=1, loadh=1, loadl=1, carry_clr=1; iter <= 0; -> TEST.
REQ-021 TEST: no loads; prod_lsb=1 -> ADD, prod_lsb=0 -> SHIFT.
REQ-022 ADD: sel_add=1, loadh=1, carry_ld=1; -> SHIFT.
REQ-023 SHIFT: shift=1, loadh=1, loadl=1, carry_clr=1; iter <= iter+1; if iter == N/2-1 -> DONE, else -> TEST.
REQ-024 The iter increment on the final SHIFT SHALL wrap to 0; iter is don't-care in DONE and IDLE.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE unconditionally; start is ignored in DONE.
REQ-026 Latency, with k = number of multiplier bits equal to 1: done is asserted in the cycle following the (17+k)-th rising edge after the edge that samples start (general form: 1+N+k).
REQ-027 start while busy SHALL be ignored; it is neither queued nor allowed to restart the operation.
REQ-028 start held high continuously SHALL give back-to-back operations with exactly one IDLE cycle between the DONE cycle and the next INIT.
REQ-029 sel_init, sel_add and shift SHALL be mutually exclusive in every cycle.
REQ-030 loadl=1 SHALL occur only together with sel_init or shift.

Reset
REQ-031 While clear=1: state=IDLE, iter=0, every output 0, independent of clk.
REQ-032 A clear asserted mid-operation SHALL abandon the operation with no done pulse; the first start after clear is released SHALL run a full operation.
REQ-033 The first rising edge after clear deasserts SHALL evaluate IDLE normally; start high on that edge -> INIT.

Verification
REQ-034 clear=1 with random start/prod_lsb -> all outputs 0, busy=0, across 20 cycles.
REQ-035 start pulse, prod_lsb held 0 (multiplier 0x00) -> 1 INIT, 8 TEST/SHIFT pairs, 0 ADD cycles, done 17 edges after start, single cycle.
REQ-036 start pulse, prod_lsb held 1 (multiplier 0xFF) -> 8 ADD cycles, done 25 edges after start.
REQ-037 Bench datapath model with register_hl, multiplicand 13, multiplier 11 -> product 0x008F (143), 3 ADD cycles, done 20 edges after start.
REQ-038 start re-pulsed during TEST/ADD/SHIFT -> no effect; clear pulsed after the 5th SHIFT -> immediate IDLE, no done pulse; the next start with 13x11 -> 143.
REQ-039 start held high for 3 operations, multiplier 0x00 -> done pulses spaced 19 cycles apart, one IDLE cycle between each DONE and the next INIT.
